inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
Instruction-fetch stage: owns the PC and issues requests to instruction memory with a req/ack handshake. It buffers the returned words and presents pc/inst pairs to the IF/ID pipeline register. It also handles downstream stall and branch redirect. This is the producer side of the IF/ID interface: it drives the if_pc/if_inst values that the IF/ID register latches.

Parameters:
ADDR_W, 32, PC / memory address width
DATA_W, 32, instruction width
RESET_PC, 32'h0000_0000, first fetch address after reset
BUF_DEPTH, 2, output buffer entries (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-low
stall_i  in  1  downstream not accepting; head entry held
branch_flag_i  in  1  one-cycle redirect strobe
branch_target_i  in  ADDR_W  redirect address
rom_req_o  out  1  memory request
rom_addr_o  out  ADDR_W  request address; stable while req high and not acked
rom_ack_i  in  1  response valid; rom_data_i belongs to current rom_addr_o
rom_data_i  in  DATA_W  fetched instruction
if_valid_o  out  1  head entry valid
if_pc_o  out  ADDR_W  head pc
if_inst_o  out  DATA_W  head instruction
if_exc_o  out  1  present only with FETCH_ALIGN_CHECK_EN

Behaviour:
- Reset (rst=0, async): pc=RESET_PC; buffer empty; state IDLE; rom_req_o=0, rom_addr_o=0, if_valid_o=0, if_pc_o=0, if_inst_o=0, if_exc_o=0.
- States:
  - IDLE: 1st edge after reset release -> REQ.
  - REQ: rom_req_o=1, rom_addr_o=pc.
  - HOLD: buffer full, req=0.
  - DROP: finish an in-flight request after a redirect, discarding its data.
- Memory handshake: once raised, rom_req_o stays high with a stable address until rom_ack_i. Same-cycle ack is legal (zero-wait memory), giving 1 instr/cycle.
- REQ with ack: push {pc, rom_data_i}; pc <= pc+4, wrapping mod 2^ADDR_W. Stay in REQ if occupancy after this edge's push/pop < BUF_DEPTH, else go to HOLD.
- HOLD -> REQ on the edge where a pop frees an entry.
- Output: if_valid_o = buffer non-empty; head drives if_pc_o/if_inst_o. When empty both read ZeroWord, i.e. a NOP bubble.
- Pop on a cycle with if_valid_o & !stall_i. Simultaneous push and pop at full is legal; occupancy is unchanged.
- Redirect (branch_flag_i=1):
  - Highest priority over push, pop and stall.
  - Buffer is flushed on that edge; pc <= {branch_target_i[ADDR_W-1:2],2'b00}.
  - If a request is outstanding and not acked that cycle, go to DROP: keep req and the old address until ack, discard the data, then REQ at the target.
  - If acked in the same cycle as the redirect: discard the data, and REQ at the target next cycle.
  - A redirect while in DROP updates the target and stays in DROP.
- Stall never blocks a redirect flush.
- Reset mid-transaction abandons the outstanding request; the memory must tolerate a dropped req.

Optional Feature:
Macro FETCH_ALIGN_CHECK_EN.
- Defined:
  - A redirect with target[1:0]!=0 issues no memory request.
  - It pushes one entry {target, ZeroWord} with if_exc_o=1 while that entry is head.
  - Fetch halts in state EXC with req=0 until the next redirect.
- Undefined: target low bits are forced to 00; if_exc_o port and EXC state do not exist.

Decomposition:
- Shared defines/package: ZeroWord, NOP encoding, active-low reset level constant, InstAddrBus/InstBus widths, fetch state encoding.
- One sub-module, fetch_buf: BUF_DEPTH-entry FIFO of {pc,inst[,exc]} with synchronous flush, push/pop and full/empty flags.

Test Plan:
1. Release reset, rom_ack_i tied to rom_req_o, stall_i=0 -> if_pc_o = 0x0,0x4,0x8,0xC on consecutive cycles, if_valid_o=1 throughout.
2. ack delayed 3 cycles per request -> rom_addr_o=0x4 stable for 4 cycles; each pc appears exactly once with the matching instruction, no duplicates.
3. Zero-wait memory, stall_i=1 for 5 cycles -> occupancy reaches 2 and rom_req_o drops; if_pc_o held. After release, pcs continue contiguously with no loss.
4. Redirect to 0x100 while the request for 0x8 is pending, ack 2 cycles later -> 0x8 data discarded, buffer empty, next valid if_pc_o=0x100.
5. Redirect to 0x200 in the same cycle as ack, stall_i=1 and a full buffer -> buffer cleared; the next valid entry is 0x200.
6. Assert rst mid-request -> outputs zero immediately, with no clock edge needed; restart at RESET_PC. With FETCH_ALIGN_CHECK_EN defined, redirect to 0x102 -> one entry pc=0x102, inst=0, if_exc_o=1, and no further rom_req_o.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, the
// all-zero bubble word, reset level and the fetch FSM encoding.
// The EXC state exists only when FETCH_ALIGN_CHECK_EN is defined.
package inst_fetch_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [InstBus-1:0] ZeroWord = '0;
  // The pipeline treats the all-zero word as its NOP bubble.
  localparam logic [InstBus-1:0] NopInst  = ZeroWord;

  // Reset is active-low.
  localparam logic RstEnable = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_HOLD = 3'd2,
    S_DROP = 3'd3
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    S_EXC  = 3'd4
`endif
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch_buf.sv
// fetch_buf: small FIFO of fetched {pc, inst[, exc]} entries.
// Flush is synchronous and wins over push/pop; a push on the flush edge
// lands as the only entry. With FETCH_ALIGN_CHECK_EN an exc bit rides along.
module fetch_buf
  import inst_fetch_pkg::*;
#(
  parameter int ADDR_W = InstAddrBus,
  parameter int DATA_W = InstBus,
  parameter int DEPTH  = 2,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [DATA_W-1:0] push_inst,
`ifdef FETCH_ALIGN_CHECK_EN
  input  logic              push_exc,
  output logic              head_exc,
`endif
  output logic [ADDR_W-1:0] head_pc,
  output logic [DATA_W-1:0] head_inst,
  output logic              empty,
  output logic              full,
  output logic [CW-1:0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] inst_mem [DEPTH];
`ifdef FETCH_ALIGN_CHECK_EN
  logic              exc_mem  [DEPTH];
`endif
  logic [PW-1:0]     rd_ptr, wr_ptr, wr_idx;
  logic              do_push, do_pop, we;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  // Push at full is only taken together with a pop (occupancy unchanged).
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign we      = flush ? push : do_push;
  assign wr_idx  = flush ? '0 : wr_ptr;

  // Entry storage; contents are don't-care until counted valid.
  always_ff @(posedge clk) begin
    if (we) begin
      pc_mem[wr_idx]   <= push_pc;
      inst_mem[wr_idx] <= push_inst;
`ifdef FETCH_ALIGN_CHECK_EN
      exc_mem[wr_idx]  <= push_exc;
`endif
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= push ? PW'(1) : '0;
      count  <= push ? CW'(1) : '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Empty buffer presents a zero pc and the NOP bubble.
  assign head_pc   = empty ? '0 : pc_mem[rd_ptr];
  assign head_inst = empty ? DATA_W'(NopInst) : inst_mem[rd_ptr];
`ifdef FETCH_ALIGN_CHECK_EN
  assign head_exc  = !empty && exc_mem[rd_ptr];
`endif

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, runs the req/ack handshake to
// instruction memory, buffers returned words and presents pc/inst to IF/ID.
// Redirects flush the buffer; an in-flight request is finished in DROP and
// its data thrown away. FETCH_ALIGN_CHECK_EN adds misaligned-target trapping
// (if_exc_o port and EXC state).
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int              ADDR_W    = InstAddrBus,
  parameter int              DATA_W    = InstBus,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              rom_req_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic              rom_ack_i,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic              if_valid_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [DATA_W-1:0] if_inst_o
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic              if_exc_o
`endif
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_t      state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, drop_addr, drop_addr_n, tgt;
  logic              buf_flush, buf_push, buf_pop, buf_empty, buf_full;
  logic [ADDR_W-1:0] push_pc;
  logic [DATA_W-1:0] push_inst;
  logic [CW-1:0]     buf_count;
`ifdef FETCH_ALIGN_CHECK_EN
  logic              push_exc, tgt_mis;

  assign tgt     = branch_target_i;
  assign tgt_mis = |branch_target_i[1:0];
`else
  // Without the alignment check the low two bits are simply ignored.
  assign tgt     = branch_target_i & ~ADDR_W'(3);
`endif

  // A redirect cancels any pop; the flush takes the head with it.
  assign buf_pop    = !buf_empty && !stall_i && !branch_flag_i;
  assign if_valid_o = !buf_empty;

  // Next-state, handshake outputs and buffer controls.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    drop_addr_n = drop_addr;
    rom_req_o   = 1'b0;
    rom_addr_o  = '0;
    buf_flush   = 1'b0;
    buf_push    = 1'b0;
    push_pc     = pc;
    push_inst   = rom_data_i;
`ifdef FETCH_ALIGN_CHECK_EN
    push_exc    = 1'b0;
`endif

    case (state)
      S_REQ:  begin rom_req_o = 1'b1; rom_addr_o = pc;        end
      S_DROP: begin rom_req_o = 1'b1; rom_addr_o = drop_addr; end
      default: ;
    endcase

    if (branch_flag_i) begin
      buf_flush = 1'b1;
      pc_n      = tgt;
      if (rom_req_o && !rom_ack_i) begin
        // Keep the old request alive until memory answers it.
        state_n = S_DROP;
        if (state == S_REQ) drop_addr_n = pc;
      end
`ifdef FETCH_ALIGN_CHECK_EN
      else if (tgt_mis) begin
        buf_push  = 1'b1;
        push_pc   = tgt;
        push_inst = '0;
        push_exc  = 1'b1;
        state_n   = S_EXC;
      end
`endif
      else begin
        state_n = S_REQ;
      end
    end else begin
      case (state)
        S_IDLE: state_n = S_REQ;
        S_REQ: begin
          if (rom_ack_i) begin
            buf_push = 1'b1;
            pc_n     = pc + ADDR_W'(4);
            if ((int'(buf_count) + 1 - int'(buf_pop)) >= BUF_DEPTH) state_n = S_HOLD;
          end
        end
        S_HOLD: if (buf_pop || !buf_full) state_n = S_REQ;
        S_DROP: begin
          if (rom_ack_i) begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (|pc[1:0]) begin
              buf_push  = 1'b1;
              push_pc   = pc;
              push_inst = '0;
              push_exc  = 1'b1;
              state_n   = S_EXC;
            end else
`endif
            state_n = S_REQ;
          end
        end
        default: ;
      endcase
    end
  end

  // State, PC and the address of the request being dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      drop_addr <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      drop_addr <= drop_addr_n;
    end
  end

  fetch_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (buf_flush),
    .push      (buf_push),
    .pop       (buf_pop),
    .push_pc   (push_pc),
    .push_inst (push_inst),
`ifdef FETCH_ALIGN_CHECK_EN
    .push_exc  (push_exc),
    .head_exc  (if_exc_o),
`endif
    .head_pc   (if_pc_o),
    .head_inst (if_inst_o),
    .empty     (buf_empty),
    .full      (buf_full),
    .count     (buf_count)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: stimulus pushes hand-listed expected pc/inst entries
// into a queue, a negedge monitor pops and compares on every accepted output.
// Memory model: ack after ack_delay wait cycles (or forced), word = addr ^ key.
module tb_inst_fetch;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          stall = 1'b1;
  logic          br = 1'b0;
  logic [AW-1:0] br_tgt = '0;
  logic          req, ack;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          vld;
  logic [AW-1:0] ipc;
  logic [DW-1:0] iinst;
`ifdef FETCH_ALIGN_CHECK_EN
  logic          iexc;
`endif

  int total = 0;
  int bad = 0;
  int ack_delay = 0;
  logic ack_force = 1'b0;
  int wait_cnt = 0;
  int addr_hits = 0;
  logic [AW-1:0] hit_addr = 32'h4;
  logic prev_pend = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] inst;
    logic          exc;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  assign ack  = req && (ack_force || (wait_cnt >= ack_delay));
  assign data = mem_word(addr);

  inst_fetch #(
    .ADDR_W(AW), .DATA_W(DW), .RESET_PC(32'h0), .BUF_DEPTH(2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall),
    .branch_flag_i   (br),
    .branch_target_i (br_tgt),
    .rom_req_o       (req),
    .rom_addr_o      (addr),
    .rom_ack_i       (ack),
    .rom_data_i      (data),
    .if_valid_o      (vld),
    .if_pc_o         (ipc),
    .if_inst_o       (iinst)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .if_exc_o        (iexc)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory wait-state counter.
  always @(posedge clk) begin
    if (!rst) wait_cnt <= 0;
    else if (req && !ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  // Monitor: handshake stability, bubble contents, scoreboard on accepts.
  always @(negedge clk) begin
    if (rst) begin
      if (prev_pend) begin
        check("req_held", req, 1);
        check("addr_stable", addr, prev_addr);
      end
      if (req && addr == hit_addr) addr_hits <= addr_hits + 1;
      if (!vld) begin
        check("bubble_pc", ipc, 0);
        check("bubble_inst", iinst, 0);
      end
      if (vld && !stall && !br) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got pc %0h, expected no output", ipc);
        end else begin
          check("out_pc", ipc, q[0].pc);
          check("out_inst", iinst, q[0].inst);
`ifdef FETCH_ALIGN_CHECK_EN
          check("out_exc", iexc, q[0].exc);
`endif
          void'(q.pop_front());
        end
      end
      prev_pend <= req && !ack;
      prev_addr <= addr;
    end else begin
      prev_pend <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    br = 1'b0;
    ack_force = 1'b0;
    q.delete();
    repeat (2) tick();
  endtask

  task automatic expect_seq(input logic [AW-1:0] base, input int n);
    for (int i = 0; i < n; i++)
      q.push_back('{pc: base + AW'(4 * i), inst: mem_word(base + AW'(4 * i)), exc: 1'b0});
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while (q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    check(name, 64'(q.size()), 0);
    stall = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1);
  end

  initial begin
    int k;
    int h0;

    // 1: reset values, then zero-wait streaming
    do_reset();
    check("rst_req", req, 0);
    check("rst_addr", addr, 0);
    check("rst_valid", vld, 0);
    check("rst_pc", ipc, 0);
    check("rst_inst", iinst, 0);
    ack_delay = 0;
    stall = 1'b0;
    expect_seq(32'h0, 8);
    rst = 1'b1;
    k = 0;
    while (!vld && k < 10) begin tick(); k++; end
    check("t1_first_valid", vld, 1);
    for (int i = 0; i < 4; i++) begin
      check("t1_valid", vld, 1);
      check("t1_pc", ipc, 4 * i);
      tick();
    end
    drain("t1_drain", 20);

    // 2: three wait states per request
    do_reset();
    ack_delay = 3;
    stall = 1'b0;
    h0 = addr_hits;
    expect_seq(32'h0, 4);
    rst = 1'b1;
    drain("t2_drain", 100);
    check("t2_addr4_cycles", 64'(addr_hits - h0), 4);

    // 3: stall fills the buffer, req drops, head held, then resumes
    do_reset();
    ack_delay = 0;
    stall = 1'b0;
    expect_seq(32'h0, 8);
    rst = 1'b1;
    k = 0;
    while (q.size() != 6 && k < 20) begin tick(); k++; end
    check("t3_two_taken", 64'(q.size()), 6);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_pc", ipc, 32'h8);
      check("t3_hold_valid", vld, 1);
      if (i >= 1) check("t3_req_drop", req, 0);
      tick();
    end
    stall = 1'b0;
    drain("t3_drain", 30);

    // 4: redirect while request for 0x8 is pending, ack two cycles later
    do_reset();
    ack_delay = 1;
    stall = 1'b0;
    expect_seq(32'h0, 2);
    rst = 1'b1;
    k = 0;
    while (!(req && addr == 32'h8) && k < 30) begin tick(); k++; end
    check("t4_reach_8", 64'(req && addr == 32'h8), 1);
    ack_delay = 1000;
    tick();
    check("t4_pre_empty", 64'(q.size()), 0);
    br = 1'b1;
    br_tgt = 32'h100;
    tick();
    br = 1'b0;
    check("t4_drop_req", req, 1);
    check("t4_drop_addr", addr, 32'h8);
    check("t4_flushed", vld, 0);
    tick();
    ack_force = 1'b1;
    expect_seq(32'h100, 3);
    tick();
    ack_force = 1'b0;
    ack_delay = 0;
    check("t4_req_tgt", addr, 32'h100);
    drain("t4_drain", 20);

    // 5: redirect on an acked cycle while stalled, then redirect from HOLD
    do_reset();
    ack_delay = 0;
    stall = 1'b1;
    rst = 1'b1;
    k = 0;
    while (!vld && k < 10) begin tick(); k++; end
    check("t5_acked_cycle", 64'(ack && addr == 32'h4), 1);
    br = 1'b1;
    br_tgt = 32'h200;
    tick();
    br = 1'b0;
    check("t5_flushed", vld, 0);
    check("t5_addr_tgt", addr, 32'h200);
    expect_seq(32'h200, 3);
    stall = 1'b0;
    drain("t5_drain", 20);
    repeat (3) tick();
    check("t5_full_hold_req", req, 0);
    br = 1'b1;
    br_tgt = 32'h301;
`ifdef FETCH_ALIGN_CHECK_EN
    br_tgt = 32'h300;
`endif
    tick();
    br = 1'b0;
    check("t5_hold_flushed", vld, 0);
    check("t5_hold_addr", addr, 32'h300);

    // 6: asynchronous reset mid-request, then restart at RESET_PC
    do_reset();
    ack_delay = 3;
    stall = 1'b0;
    expect_seq(32'h0, 2);
    rst = 1'b1;
    k = 0;
    while (!(vld && ipc == 32'h4) && k < 40) begin tick(); k++; end
    check("t6_mid_req", 64'(req && addr == 32'h8), 1);
    #1 rst = 1'b0;
    #1;
    check("t6_req", req, 0);
    check("t6_addr", addr, 0);
    check("t6_valid", vld, 0);
    check("t6_pc", ipc, 0);
    check("t6_inst", iinst, 0);
    q.delete();
    tick();
    ack_delay = 0;
    expect_seq(32'h0, 4);
    rst = 1'b1;
    drain("t6_drain", 20);

`ifdef FETCH_ALIGN_CHECK_EN
    repeat (3) tick();
    br = 1'b1;
    br_tgt = 32'h102;
    tick();
    br = 1'b0;
    check("exc_valid", vld, 1);
    check("exc_pc", ipc, 32'h102);
    check("exc_inst", iinst, 0);
    check("exc_flag", iexc, 1);
    q.push_back('{pc: 32'h102, inst: '0, exc: 1'b1});
    stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("exc_no_req", req, 0);
      tick();
    end
    check("exc_drained", 64'(q.size()), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
